// File: rtl/fsmc_master.sv
// fsmc_master: FSMC bus initiator with multiplexed address/data (NADV/NWE/NOE/AD).
// It accepts single-word read/write requests on a valid/ready port and runs
// one timed bus cycle per request: address setup, address hold, data strobe
// and bus turnaround. All pins are registered.
module fsmc_master #(
  parameter int unsigned AW      = 18,
  parameter int unsigned DW      = 16,
  parameter int unsigned ADDSET  = 4,
  parameter int unsigned ADDHLD  = 2,
  parameter int unsigned DATAST  = 8,
  parameter int unsigned BUSTURN = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          NADV,
  output logic          NWE,
  output logic          NOE,
  inout  wire  [AW-1:0] AD
);

  // Elaboration-time parameter range checks
  if (ADDSET < 1 || ADDSET > 255) begin : g_bad_addset
    $error("fsmc_master: ADDSET must be in 1..255");
  end
  if (ADDHLD < 1 || ADDHLD > 255) begin : g_bad_addhld
    $error("fsmc_master: ADDHLD must be in 1..255");
  end
  if (DATAST < 1 || DATAST > 255) begin : g_bad_datast
    $error("fsmc_master: DATAST must be in 1..255");
  end
  if (BUSTURN < 1 || BUSTURN > 255) begin : g_bad_busturn
    $error("fsmc_master: BUSTURN must be in 1..255");
  end
  if (AW < DW) begin : g_bad_width
    $error("fsmc_master: AW must be >= DW");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_AHOLD = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;

  // Counter load values: a phase lasts (load + 1) cycles, leaving on count zero
  localparam logic [7:0] ADDSET_LD  = 8'(ADDSET - 1);
  localparam logic [7:0] ADDHLD_LD  = 8'(ADDHLD - 1);
  localparam logic [7:0] DATAST_LD  = 8'(DATAST - 1);
  localparam logic [7:0] BUSTURN_LD = 8'(BUSTURN - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_d;
  logic [AW-1:0] ad_out_q, ad_out_d;
  logic          ad_oe_q, ad_oe_d;
  logic          nadv_d, nwe_d, noe_d, ready_d, done_d;
  logic          last;

  assign AD = ad_oe_q ? ad_out_q : {AW{1'bz}};

  // Next state, request capture, read sampling, and pin values for the next state.
  // Pins are decoded from the next state so the registered pins line up with
  // the registered state without an extra cycle of delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata;
    last    = (cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ADDR;
          cnt_d   = ADDSET_LD;
        end
      end
      S_ADDR: begin
        if (last) begin
          state_d = S_AHOLD;
          cnt_d   = ADDHLD_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_AHOLD: begin
        if (last) begin
          state_d = S_DATA;
          cnt_d   = DATAST_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DATA: begin
        if (last) begin
          state_d = S_TURN;
          cnt_d   = BUSTURN_LD;
          if (!wr_q) begin
            rdata_d = AD[DW-1:0];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_TURN: begin
        if (last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    nadv_d  = (state_d != S_ADDR);
    nwe_d   = !(wr_d && (state_d == S_AHOLD || state_d == S_DATA));
    noe_d   = !(!wr_d && state_d == S_DATA);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_TURN) && (state_d == S_IDLE);

    ad_out_d = '0;
    ad_oe_d  = 1'b0;
    if (state_d == S_ADDR || state_d == S_AHOLD) begin
      ad_out_d = addr_d;
      ad_oe_d  = 1'b1;
    end else if (wr_d && (state_d == S_DATA || state_d == S_TURN)) begin
      ad_out_d[DW-1:0] = wdata_d;
      ad_oe_d          = 1'b1;
    end
  end

  // State, captured request, and registered pins; reset forces the bus idle at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
      NADV      <= 1'b1;
      NWE       <= 1'b1;
      NOE       <= 1'b1;
      req_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata     <= rdata_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      NADV      <= nadv_d;
      NWE       <= nwe_d;
      NOE       <= noe_d;
      req_ready <= ready_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_fsmc_master.sv
// tb_fsmc_master: randomized bench for fsmc_master with a responder on AD.
// Expected pin values are derived per cycle from the phase lengths.
module tb_fsmc_master;

  localparam int A = 4;
  localparam int H = 2;
  localparam int D = 8;
  localparam int T = 3;
  localparam int L = A + H + D + T + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_wr, req_ready, done;
  logic [17:0] req_addr;
  logic [15:0] req_wdata, rdata;
  logic        NADV, NWE, NOE;
  wire  [17:0] AD;
  logic [15:0] resp_data;

  logic        v1_valid, v1_wr, v1_ready, v1_done;
  logic [17:0] v1_addr;
  logic [15:0] v1_wdata, v1_rdata;
  logic        v1_nadv, v1_nwe, v1_noe;
  wire  [17:0] AD1;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_rdata;

  always #5 clk = ~clk;

  // Responder: drives the data lanes while the read strobe is low
  assign AD[15:0] = (NOE == 1'b0) ? resp_data : 16'bz;

  fsmc_master #(
    .AW(18), .DW(16), .ADDSET(A), .ADDHLD(H), .DATAST(D), .BUSTURN(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rdata(rdata), .NADV(NADV), .NWE(NWE), .NOE(NOE), .AD(AD)
  );

  fsmc_master #(
    .AW(18), .DW(16), .ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(1)
  ) dut_fast (
    .clk(clk), .reset_n(reset_n), .req_valid(v1_valid), .req_ready(v1_ready),
    .req_wr(v1_wr), .req_addr(v1_addr), .req_wdata(v1_wdata), .done(v1_done),
    .rdata(v1_rdata), .NADV(v1_nadv), .NWE(v1_nwe), .NOE(v1_noe), .AD(AD1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Undriven (z) or unknown bits read as 0, so "Hi-Z" is expected as 0
  function automatic logic [17:0] seen(input logic [17:0] v);
    logic [17:0] r;
    for (int i = 0; i < 18; i++) r[i] = (v[i] === 1'b1);
    return r;
  endfunction

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle done", done, 1'b0);
      check_eq("idle ready", req_ready, 1'b1);
      check_eq("idle strobes", {NADV, NWE, NOE}, 3'b111);
      check_eq("idle AD", seen(AD), 18'h0);
      check_eq("idle rdata", rdata, exp_rdata);
    end
  endtask

  // Issue one request at a sample point where ready must be high, then check
  // every cycle until done. Returns at the sample point of the done cycle.
  task automatic run_txn(input bit wr, input logic [17:0] a, input logic [15:0] d,
                         input logic [15:0] rd_val);
    logic e_nadv, e_nwe, e_noe;
    logic [17:0] e_ad;
    check_eq("ready at issue", req_ready, 1'b1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    resp_data = rd_val;
    @(posedge clk);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      e_nadv = !(k <= A);
      e_nwe  = !(wr && k > A && k <= A + H + D);
      e_noe  = !(!wr && k > A + H && k <= A + H + D);
      if (k <= A + H)                   e_ad = a;
      else if (wr && k <= A + H + D + T) e_ad = {2'b00, d};
      else if (!wr && k <= A + H + D)    e_ad = {2'b00, rd_val};
      else                               e_ad = 18'h0;
      check_eq($sformatf("NADV k=%0d", k), NADV, e_nadv);
      check_eq($sformatf("NWE k=%0d", k), NWE, e_nwe);
      check_eq($sformatf("NOE k=%0d", k), NOE, e_noe);
      check_eq($sformatf("AD k=%0d", k), seen(AD), e_ad);
      check_eq($sformatf("done k=%0d", k), done, (k == L));
      check_eq($sformatf("ready k=%0d", k), req_ready, (k == L));
      if (k == L) begin
        if (!wr) exp_rdata = rd_val;
        check_eq("rdata at done", rdata, exp_rdata);
      end else begin
        if (wr) check_eq($sformatf("rdata held k=%0d", k), rdata, exp_rdata);
        // Garbage on the request port must not disturb the bus cycle
        req_valid = 1'($urandom);
        req_wr    = 1'($urandom);
        req_addr  = 18'($urandom);
        req_wdata = 16'($urandom);
        if (!wr && k > A + H + D) resp_data = 16'($urandom);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    resp_data = '0;
    v1_valid  = 1'b0;
    v1_wr     = 1'b0;
    v1_addr   = '0;
    v1_wdata  = '0;
    exp_rdata = '0;

    repeat (3) @(negedge clk);
    check_eq("reset strobes", {NADV, NWE, NOE}, 3'b111);
    check_eq("reset ready", req_ready, 1'b1);
    check_eq("reset done", done, 1'b0);
    check_eq("reset rdata", rdata, 16'h0);
    check_eq("reset AD", seen(AD), 18'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: write, then read accepted in the write's done cycle
    run_txn(1'b1, 18'h00101, 16'h0F0F, 16'h0000);
    run_txn(1'b0, 18'h00101, 16'h0000, 16'h2321);
    idle_cycles(2);
    run_txn(1'b1, 18'h2AAAA, 16'hFFFF, 16'h0000);
    idle_cycles(1);

    // Random mix of reads and writes, back-to-back or with idle gaps
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), 18'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    // Reset during the third DATA cycle of a write
    check_eq("ready before abort", req_ready, 1'b1);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 18'h15A5A;
    req_wdata = 16'hBEEF;
    @(posedge clk);
    repeat (A + H + 3) @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort NWE before", NWE, 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("abort NWE", NWE, 1'b1);
    check_eq("abort AD", seen(AD), 18'h0);
    check_eq("abort NADV", NADV, 1'b1);
    exp_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < L + 5; i++) begin
      @(negedge clk);
      check_eq("abort no done", done, 1'b0);
      check_eq("abort ready", req_ready, 1'b1);
    end

    // One-cycle phases on the second instance
    v1_valid = 1'b1;
    v1_wr    = 1'b1;
    v1_addr  = 18'h3C3C3;
    v1_wdata = 16'h5AA5;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      v1_valid = 1'b0;
      check_eq($sformatf("fast NADV k=%0d", k), v1_nadv, (k != 1));
      check_eq($sformatf("fast NWE k=%0d", k), v1_nwe, !(k == 2 || k == 3));
      check_eq($sformatf("fast NOE k=%0d", k), v1_noe, 1'b1);
      check_eq($sformatf("fast done k=%0d", k), v1_done, (k == 5));
      check_eq($sformatf("fast AD k=%0d", k), seen(AD1),
               (k <= 2) ? 18'h3C3C3 : ((k <= 4) ? 18'h05AA5 : 18'h0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
